// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory req/ack read, and IR for the multicycle core.
// Ports: CLK/RST_N, FETCH_REQ/PCWRITE/PC_SEL + targets in; IMEM_* handshake; PC, PC_PLUS4, IR, OPCODE, status out.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FETCH_REQ,
    input  logic        PCWRITE,
    input  logic [1:0]  PC_SEL,
    input  logic [31:0] JALR_TGT,
    input  logic [31:0] BRANCH_TGT,
    input  logic [31:0] JAL_TGT,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] IR,
    output logic [6:0]  OPCODE,
    output logic        IR_VALID,
    output logic        FETCH_BUSY,
    output logic        MISALIGN,
    output logic        ERR
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [31:0] target;

    assign PC_PLUS4  = PC + 32'd4;
    assign IMEM_ADDR = PC;
    assign OPCODE    = IR[6:0];
    assign cnt_nxt   = cnt + 8'd1;

    always_comb begin
        target = PC_PLUS4;
        unique case (PC_SEL)
            2'd0: target = PC_PLUS4;
            2'd1: target = JALR_TGT;
            2'd2: target = BRANCH_TGT;
            2'd3: target = JAL_TGT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            PC         <= RESET_VECTOR;
            IR         <= NOP;
            IR_VALID   <= 1'b0;
            IMEM_REQ   <= 1'b0;
            FETCH_BUSY <= 1'b0;
            MISALIGN   <= 1'b0;
            ERR        <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            MISALIGN <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (PCWRITE) begin
                        if (target[1:0] == 2'b00) begin
                            PC       <= target;
                            IR_VALID <= 1'b0;
                        end else begin
                            MISALIGN <= 1'b1;
                        end
                    end
                    // Fetch reads IMEM_ADDR=PC, so a same-cycle PC write is
                    // naturally the address fetched.
                    if (FETCH_REQ) begin
                        state      <= WAIT;
                        IMEM_REQ   <= 1'b1;
                        FETCH_BUSY <= 1'b1;
                        IR_VALID   <= 1'b0;
                        cnt        <= 8'd0;
                    end
                end
                WAIT: begin
                    if (PCWRITE) begin
                        ERR <= 1'b1;
                    end
                    if (IMEM_ACK) begin
                        IR         <= IMEM_DATA;
                        IR_VALID   <= 1'b1;
                        IMEM_REQ   <= 1'b0;
                        FETCH_BUSY <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == TO_LIMIT) begin
                            IMEM_REQ   <= 1'b0;
                            FETCH_BUSY <= 1'b0;
                            ERR        <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
